// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the load/store
// unit. Word-organised RAM with byte/halfword store merge; loads return the
// full aligned word on the shared memout bus during the one-cycle response.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request with sel != 1000
// WAIT  | counting wait states after accept
// RESP  | ready high for one cycle; store commits / load data on memout
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] address,
    input  logic [3:0]  sel,
    input  logic        write,
    inout  wire  [31:0] memout,
    output logic        ready,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // WS_LAST is unused (and wraps) when WAIT_STATES is 0: WAIT is unreachable then.
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  sel_q;
    logic        write_q;
    logic        accept;
    logic        bad;
    logic        drive;
    logic [AW-1:0] widx;
    logic [AW-1:0] rd_idx;
    logic [31:0] ram [DEPTH_WORDS];

    assign accept = (state == S_IDLE) && req && (sel != 4'b1000);
    assign widx   = addr_q[AW+1:2];
    // With zero wait states the read happens on the accept edge, before the
    // address has been latched, so IDLE reads through the live address.
    assign rd_idx = (state == S_IDLE) ? address[AW+1:2] : addr_q[AW+1:2];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == WS_LAST) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Access rejection, evaluated on the latched request.
    always_comb begin
        bad = 1'b0;
        case (sel_q)
            4'b0001: bad = (addr_q[1:0] != 2'b00);
            4'b0010: bad = addr_q[0];
            4'b0100: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        if (addr_q[31:AW+2] != '0) bad = 1'b1;
    end

    // Moore outputs from the current state.
    always_comb begin
        ready = (state == S_RESP);
        fault = ready && bad;
        drive = ready && !write_q && !bad;
    end

    assign memout = drive ? rdata_q : 'z;

    // Request latch, wait counter and registered read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                addr_q  <= address;
                wdata_q <= memout;
                sel_q   <= sel;
                write_q <= write;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (state != S_RESP && state_nx == S_RESP) rdata_q <= ram[rd_idx];
        end
    end

    // RAM store merge at the response edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && write_q && !bad) begin
            case (sel_q)
                4'b0100: begin
                    case (addr_q[1:0])
                        2'd0: ram[widx][7:0]   <= wdata_q[7:0];
                        2'd1: ram[widx][15:8]  <= wdata_q[7:0];
                        2'd2: ram[widx][23:16] <= wdata_q[7:0];
                        default: ram[widx][31:24] <= wdata_q[7:0];
                    endcase
                end
                4'b0010: begin
                    if (addr_q[1]) ram[widx][31:16] <= wdata_q[15:0];
                    else           ram[widx][15:0]  <= wdata_q[15:0];
                end
                default: ram[widx] <= wdata_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized accesses
// checked against a byte-addressed memory model.
module tb_dmem_responder;

    localparam int WS    = 1;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  sel = 4'b1000;
    logic        write = 1'b0;
    logic [31:0] tb_drv = '0;
    logic        tb_en = 1'b1;
    logic        tb_en0 = 1'b1;
    wire  [31:0] memout;
    wire  [31:0] memout0;
    logic        ready, fault, ready0, fault0;

    int ncmp = 0;
    int nfail = 0;

    logic [7:0] mb [0:DEPTH*4-1];

    assign memout  = tb_en  ? tb_drv : 'z;
    assign memout0 = tb_en0 ? tb_drv : 'z;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .req(req), .address(address), .sel(sel),
        .write(write), .memout(memout), .ready(ready), .fault(fault));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .address(address), .sel(sel),
        .write(write), .memout(memout0), .ready(ready0), .fault(fault0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_fault(input logic [3:0] s, input logic [31:0] a);
        if (s != 4'b0001 && s != 4'b0010 && s != 4'b0100) return 1'b1;
        if (s == 4'b0001 && (a % 4) != 0) return 1'b1;
        if (s == 4'b0010 && (a % 2) != 0) return 1'b1;
        if (a >= DEPTH * 4) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a & 32'h0000_0FFC);
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic model_store(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (s == 4'b0100) ? 1 : (s == 4'b0010) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[int'(a) + i] = d[8*i +: 8];
    endtask

    // One access on the WAIT_STATES=1 instance; lat = -1 if ready never came.
    task automatic access(input logic [3:0] s, input logic [31:0] a, input bit w,
                          input logic [31:0] d, input bit drv,
                          output int lat, output bit flt, output logic [31:0] rd);
        @(negedge clk);
        address = a; sel = s; write = w; tb_drv = drv ? d : 32'h0; tb_en = drv; req = 1'b1;
        @(posedge clk);
        lat = -1; flt = 1'b0; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k; flt = fault; rd = memout;
                break;
            end
        end
        req = 1'b0; tb_en = 1'b1; tb_drv = '0;
    endtask

    task automatic do_check(input string tag, input logic [3:0] s, input logic [31:0] a,
                            input bit w, input logic [31:0] d);
        int lat; bit flt; logic [31:0] rd; bit ef;
        ef = exp_fault(s, a);
        // Faulting accesses keep the bench driving 0 so any responder drive shows up.
        access(s, a, w, ef ? 32'h0 : d, w || ef, lat, flt, rd);
        check({tag, ".lat"}, 32'(lat), 32'(1 + WS));
        check({tag, ".fault"}, {31'b0, flt}, {31'b0, ef});
        if (!w && !ef) check({tag, ".data"}, rd, model_word(a));
        if (!w && ef)  check({tag, ".busz"}, rd, 32'h0);
        if (w && !ef)  model_store(s, a, d);
    endtask

    initial begin
        int cnt;
        logic [3:0] pat;
        logic [3:0] seltab [7];
        seltab = '{4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b0000, 4'b0001, 4'b0100};

        repeat (2) @(negedge clk);
        check("rst.ready", {31'b0, ready}, 32'h0);
        check("rst.fault", {31'b0, fault}, 32'h0);
        check("rst.busz", memout, 32'h0);
        rst = 1'b0;

        for (int i = 0; i <= 16; i++) begin
            do_check("init", 4'b0001, 32'(i * 4), 1'b1, 32'h0);
        end

        do_check("rt.st", 4'b0001, 32'h40, 1'b1, 32'hDEADBEEF);
        do_check("rt.ld", 4'b0001, 32'h40, 1'b0, 32'h0);
        check("rt.const", model_word(32'h40), 32'hDEADBEEF);

        do_check("mg.w",  4'b0001, 32'h10, 1'b1, 32'h11223344);
        do_check("mg.b",  4'b0100, 32'h12, 1'b1, 32'h000000AA);
        do_check("mg.l1", 4'b0001, 32'h10, 1'b0, 32'h0);
        check("mg.m1", model_word(32'h10), 32'h11AA3344);
        do_check("mg.h",  4'b0010, 32'h12, 1'b1, 32'h0000BBCC);
        do_check("mg.l2", 4'b0001, 32'h10, 1'b0, 32'h0);
        check("mg.m2", model_word(32'h10), 32'hBBCC3344);

        do_check("f.wmis", 4'b0001, 32'h42, 1'b0, 32'h0);
        do_check("f.hmis", 4'b0010, 32'h41, 1'b1, 32'h0000FFFF);
        do_check("f.unch", 4'b0001, 32'h40, 1'b0, 32'h0);
        do_check("f.range", 4'b0001, 32'h400, 1'b0, 32'h0);

        @(negedge clk);
        address = 32'h0; sel = 4'b1000; write = 1'b0; tb_en = 1'b0; req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        req = 1'b0; tb_en = 1'b1;
        check("noacc", 32'(cnt), 32'h0);
        do_check("sel3", 4'b0011, 32'h0, 1'b0, 32'h0);

        @(negedge clk);
        address = 32'h20; sel = 4'b0001; write = 1'b1; tb_drv = 32'h55555555; tb_en = 1'b1; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        cnt = 0;
        if (ready) cnt++;
        @(negedge clk);
        rst = 1'b0; tb_drv = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        check("rst.noready", 32'(cnt), 32'h0);
        do_check("rst.ld", 4'b0001, 32'h20, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] s; logic [31:0] a;
            s = seltab[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 63));
            else                           a = 32'($urandom_range(0, 67));
            do_check("rnd", s, a, 1'($urandom_range(0, 1)), $urandom);
        end

        @(negedge clk);
        address = 32'h8; sel = 4'b0001; write = 1'b1; tb_drv = 32'hCAFEF00D; tb_en0 = 1'b1; req0 = 1'b1;
        @(posedge clk);
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[k] = ready0;
            if (k == 2) req0 = 1'b0;
        end
        check("ws0.b2b", {28'b0, pat}, 32'h5);
        @(negedge clk);
        write = 1'b0; tb_en0 = 1'b0; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ws0.ready", {31'b0, ready0}, 32'h1);
        check("ws0.data", memout0, 32'hCAFEF00D);
        req0 = 1'b0; tb_en0 = 1'b1; tb_drv = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the load/store unit's memory port. It accepts one access at a time, qualified by `req`, and decodes the one-hot size code on `sel`. Stores merge byte or halfword data into the addressed lanes of a word-organised RAM. Loads return the full aligned word on the shared bidirectional `memout` bus, and the load/store unit does the lane extraction and extension.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two.
- `WAIT_STATES`, default 1: extra cycles between accept and response; range 0–15.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  1: access request. The requester holds `req`, `address`, `sel`, `write` and its store data stable until `ready`.
- `address`  in  32: byte address.
- `sel`  in  4: size code.
  - `0001` = word.
  - `0010` = halfword.
  - `0100` = byte.
  - `1000` = no access.
- `write`  in  1: 1 = store, 0 = load.
- `memout`  inout  32: shared data bus.
  - The requester drives store data.
  - The responder drives load data only in RESP of a non-faulting load; it is high-Z otherwise.
- `ready`  out  1: single-cycle response strobe.
- `fault`  out  1: valid with `ready`; the access was rejected.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req=1` with `sel=1000`: ignored, and the FSM stays in IDLE.
  - `req=1` with any other `sel`: accepted. Latch `address`, `sel`, `write`, and `memout` as the store-data register, then go to WAIT, or to RESP if `WAIT_STATES=0`.
  - Clear the wait counter on accept.
- **WAIT**: the counter increments each cycle. When counter = `WAIT_STATES`−1, go to RESP.
- **RESP**: assert `ready` for exactly one cycle, then return to IDLE. A `req` seen in RESP is not accepted; it is sampled in the following IDLE cycle.
- Fault checks are evaluated on the latched values; any one of them sets `fault=1` in RESP:
  - `sel` not one of `0001`, `0010`, `0100`.
  - Word with `address[1:0]≠0`.
  - Halfword with `address[0]=1`.
  - `address[31:2] ≥ DEPTH_WORDS`.
- A faulting access does not write the RAM and does not drive `memout`.
- Word index is `address[log2(DEPTH_WORDS)+1:2]`.
- **Store**, RAM written at the RESP clock edge:
  - Byte: data `[7:0]` goes into lane `address[1:0]` (lane 0 = bits `[7:0]`).
  - Half: data `[15:0]` goes into bits `[15:0]` if `address[1]=0`, else bits `[31:16]`.
  - Word: all 32 bits.
  - Unselected lanes keep their value.
- **Load**: RAM read in the cycle before RESP into a registered read word. It is driven onto `memout` during RESP, always the full aligned word regardless of size.
- RAM contents are not cleared by reset and persist across it.

## Timing
- Reset values:
  - State = IDLE.
  - `ready=0`, `fault=0`.
  - `memout` high-Z.
  - Counter and latched registers = 0.
- Latency, with accept at edge N: `ready` is high during cycle N+1+`WAIT_STATES`.
  - `WAIT_STATES=0`: response in the cycle after accept.
  - Back-to-back throughput is one access per 2+`WAIT_STATES` cycles.
- `memout` is driven only while state = RESP and the latched access is a non-faulting load. There is no overlap with requester drive, because store data is sampled only at accept.
- `rst` asserted mid-access, in WAIT or RESP:
  - Immediately IDLE, `ready=0`, `memout` high-Z.
  - A store whose RESP edge has not occurred is dropped, with no RAM write.
- `fault` is meaningful only while `ready=1` and is 0 otherwise.

## Test plan
- **Word round trip** (`WAIT_STATES=1`): store word `0xDEADBEEF` at `0x40`, then load `0x40`. Required: `ready` 2 cycles after each accept, `memout=0xDEADBEEF`, `fault=0`.
- **Byte lane merge**: word `0x11223344` at `0x10`, then byte store `memout=0x000000AA` at `0x12`. A load of `0x10` returns `0x11AA3344`. A half store `0x0000BBCC` at `0x12` then gives `0xBBCC3344`.
- **Faults**:
  - Word load at `0x42`: `ready=1`, `fault=1`, `memout` stays Z.
  - Half store at `0x41`: `fault=1` and the RAM is unchanged.
  - Address `0x400` with depth 256: `fault=1`.
- **No-access and invalid `sel`**:
  - `sel=1000` with `req=1` for 5 cycles: no `ready`.
  - `sel=0011`: accepted, `ready` with `fault=1`.
- **Reset mid-store**: store `0x55555555` to `0x20` (previously `0x0`), assert `rst` during WAIT. Required: `ready` never asserts, and a later load of `0x20` returns `0x0`.
- **`WAIT_STATES=0` back-to-back**: `req` held for 2 accesses gives `ready` in cycles 1 and 3 after the first accept, and no acceptance in the RESP cycle.
